// File: rtl/regread_arbiter.sv
// Round-robin arbiter sharing one 16:1 one-hot register-read mux among NREQ requesters.
// Holds sel for SETTLE_CYCLES so the NAND tree settles, then captures mux_res and acks.
module regread_arbiter #(
    parameter int NREQ          = 4,
    parameter int WIDTH         = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [4*NREQ-1:0] addr,
    output logic [15:0]       sel,
    input  logic [WIDTH-1:0]  mux_res,
    output logic [WIDTH-1:0]  rdata,
    output logic [NREQ-1:0]   ack,
    output logic [2:0]        gnt_id,
    output logic              busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACK} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [IW-1:0]    ptr, ptr_nxt;
    logic [IW-1:0]    gnt_q, gnt_nxt;
    logic [15:0]      sel_nxt;
    logic [WIDTH-1:0] rdata_nxt;
    logic [NREQ-1:0]  ack_nxt;

    logic [NREQ-1:0]  eligible;
    logic             win_vld;
    logic [IW-1:0]    win;
    logic [IW-1:0]    cand;
    logic [3:0]       win_addr;

    // The requester just acked still holds req during ACK, so it is masked there.
    always_comb begin
        eligible = req;
        cand     = '0;
        win_vld  = 1'b0;
        win      = '0;
        win_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (state == ACK && gnt_q == IW'(i)) eligible[i] = 1'b0;
        end
        // Walk downward so the lowest offset from ptr is the last (winning) assignment.
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (eligible[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) win_addr = addr[4*i +: 4];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt_q;
        sel_nxt   = sel;
        rdata_nxt = rdata;
        ack_nxt   = '0;
        case (state)
            IDLE, ACK: begin
                if (win_vld) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = CNT_LOAD;
                    ptr_nxt   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                    gnt_nxt   = win;
                    sel_nxt   = 16'h0001 << win_addr;
                end else begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = ACK;
                    rdata_nxt = mux_res;
                    for (int i = 0; i < NREQ; i++) begin
                        ack_nxt[i] = (gnt_q == IW'(i));
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= '0;
            gnt_q <= '0;
            sel   <= '0;
            rdata <= '0;
            ack   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ptr   <= ptr_nxt;
            gnt_q <= gnt_nxt;
            sel   <= sel_nxt;
            rdata <= rdata_nxt;
            ack   <= ack_nxt;
        end
    end

    assign busy   = (state != IDLE);
    assign gnt_id = 3'(gnt_q);

endmodule

// File: tb/tb_regread_arbiter.sv
// Bench for regread_arbiter: timestamp-based transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized request traffic.
module tb_regread_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int S     = 2;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [4*NREQ-1:0] addr;
    logic [15:0]       sel;
    logic [WIDTH-1:0]  mux_res;
    logic [WIDTH-1:0]  rdata;
    logic [NREQ-1:0]   ack;
    logic [2:0]        gnt_id;
    logic              busy;

    regread_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .req(req), .addr(addr), .sel(sel),
        .mux_res(mux_res), .rdata(rdata), .ack(ack), .gnt_id(gnt_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file behind the mux; output is inverted garbage in the first cycle after sel moves.
    logic [WIDTH-1:0] regs [16];
    logic [WIDTH-1:0] mux_raw;
    logic [15:0]      sel_q;
    always_comb begin
        mux_raw = '0;
        for (int i = 0; i < 16; i++) if (sel[i]) mux_raw = mux_raw | regs[i];
    end
    always @(posedge clk) sel_q <= sel;
    assign mux_res = (sel == sel_q) ? mux_raw : ~mux_raw;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: who holds the mux, when it was granted, and the rotating pointer.
    bit               armed = 0;
    int               cur = -1;
    int               gid = 0;
    int               ptr_m = 0;
    int               cyc = 0;
    int               t_grant = 0;
    logic [3:0]       lat_addr = '0;
    logic [15:0]      m_sel = '0;
    logic [NREQ-1:0]  m_ack = '0;
    logic [WIDTH-1:0] m_rdata = '0;

    function automatic int pick(input bit mask);
        for (int i = 0; i < NREQ; i++) begin
            int j = (ptr_m + i) % NREQ;
            if (req[j] && !(mask && j == gid)) return j;
        end
        return -1;
    endfunction

    task automatic grant(input int k);
        cur      = k;
        gid      = k;
        ptr_m    = (k + 1) % NREQ;
        lat_addr = addr[4*k +: 4];
        m_sel    = 16'h0001 << lat_addr;
        t_grant  = cyc;
    endtask

    always @(posedge clk) begin
        int k;
        if (reset) begin
            armed = 1; cur = -1; gid = 0; ptr_m = 0; cyc = 0;
            m_sel = '0; m_ack = '0; m_rdata = '0;
        end else begin
            cyc++;
            if (m_ack != '0) begin
                m_ack = '0;
                k = pick(1'b1);
                if (k >= 0) grant(k);
                else begin cur = -1; m_sel = '0; end
            end else if (cur < 0) begin
                k = pick(1'b0);
                if (k >= 0) grant(k);
            end else if (cyc == t_grant + S) begin
                m_ack   = NREQ'(1) << cur;
                m_rdata = regs[lat_addr];
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (armed) begin
            check("sel", 32'(sel), 32'(m_sel));
            check("ack", 32'(ack), 32'(m_ack));
            check("busy", 32'(busy), 32'(cur >= 0));
            check("gnt_id", 32'(gnt_id), 32'(gid));
            if (m_ack != '0) check("rdata", 32'(rdata), 32'(m_rdata));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ack(output int waited);
        waited = 0;
        for (int n = 0; n < 20; n++) begin
            after_edge();
            waited++;
            if (ack != '0) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL ack_timeout: got no ack within 20 cycles, required one at %0t", $time);
    endtask

    int w;
    logic [3:0] rr_addr [4];

    initial begin
        reset = 1'b1;
        req   = '0;
        addr  = '0;
        for (int i = 0; i < 16; i++) regs[i] = WIDTH'($urandom);

        // Idle after reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            after_edge();
            check("idle_sel", 32'(sel), 0);
            check("idle_ack", 32'(ack), 0);
            check("idle_rdata", 32'(rdata), 0);
            check("idle_busy", 32'(busy), 0);
        end

        // Single read from requester 1, address 5
        regs[5] = 16'hA5C3;
        @(negedge clk);
        addr[7:4] = 4'd5;
        req = 4'b0010;
        after_edge();
        check("single_sel", 32'(sel), 32'h0020);
        check("single_gnt", 32'(gnt_id), 1);
        check("model_sel", 32'(m_sel), 32'h0020);
        wait_ack(w);
        check("single_lat", w, 2);
        check("single_ack", 32'(ack), 32'b0010);
        check("single_rdata", 32'(rdata), 32'hA5C3);
        @(negedge clk);
        req = '0;
        after_edge();
        check("single_sel_off", 32'(sel), 0);
        check("single_busy_off", 32'(busy), 0);

        // All four requesting: strict rotation, one ack every S+1 cycles
        do_reset();
        rr_addr[0] = 4'd0; rr_addr[1] = 4'd3; rr_addr[2] = 4'd7; rr_addr[3] = 4'd15;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) addr[4*i +: 4] = rr_addr[i];
        req = 4'b1111;
        for (int t = 0; t < 8; t++) begin
            wait_ack(w);
            check("rr_gap", w, 3);
            check("rr_gnt", 32'(gnt_id), t % 4);
            check("rr_ack", 32'(ack), 32'(1) << (t % 4));
            check("rr_sel", 32'(sel), 32'(1) << rr_addr[t % 4]);
            check("rr_rdata", 32'(rdata), 32'(regs[rr_addr[t % 4]]));
        end
        check("model_rr_gid", gid, 3);
        @(negedge clk);
        req = '0;

        // Sole repeater: masked in ACK, so one idle cycle between reads
        do_reset();
        @(negedge clk);
        addr[11:8] = 4'd9;
        req = 4'b0100;
        wait_ack(w);
        check("rep_first", w, 3);
        for (int t = 0; t < 3; t++) begin
            wait_ack(w);
            check("rep_gap", w, 4);
            check("rep_ack", 32'(ack), 32'b0100);
            check("rep_sel", 32'(sel), 32'h0200);
            check("rep_rdata", 32'(rdata), 32'(regs[9]));
        end
        @(negedge clk);
        req = '0;

        // Requester 0 drops during SETTLE; transaction still completes, then requester 2
        do_reset();
        @(negedge clk);
        addr[3:0] = 4'd1;
        addr[11:8] = 4'd6;
        req = 4'b0101;
        after_edge();
        check("drop_gnt", 32'(gnt_id), 0);
        check("drop_sel", 32'(sel), 32'h0002);
        @(negedge clk);
        req[0] = 1'b0;
        wait_ack(w);
        check("drop_lat", w, 2);
        check("drop_ack", 32'(ack), 32'b0001);
        check("drop_rdata", 32'(rdata), 32'(regs[1]));
        after_edge();
        check("drop_next_gnt", 32'(gnt_id), 2);
        check("drop_next_sel", 32'(sel), 32'h0040);
        wait_ack(w);
        check("drop_next_ack", 32'(ack), 32'b0100);
        @(negedge clk);
        req = '0;

        // Address moves mid-SETTLE: sel stays latched
        do_reset();
        @(negedge clk);
        addr[15:12] = 4'd2;
        req = 4'b1000;
        after_edge();
        check("hold_sel0", 32'(sel), 32'h0004);
        @(negedge clk);
        addr[15:12] = 4'd11;
        after_edge();
        check("hold_sel1", 32'(sel), 32'h0004);
        wait_ack(w);
        check("hold_ack", 32'(ack), 32'b1000);
        check("hold_sel2", 32'(sel), 32'h0004);
        check("hold_rdata", 32'(rdata), 32'(regs[2]));
        @(negedge clk);
        req = '0;

        // Reset during SETTLE abandons the read
        do_reset();
        @(negedge clk);
        addr[7:4] = 4'd3;
        req = 4'b0010;
        after_edge();
        check("rst_busy", 32'(busy), 1);
        @(negedge clk);
        reset = 1'b1;
        req = '0;
        after_edge();
        check("rst_sel", 32'(sel), 0);
        check("rst_busy_off", 32'(busy), 0);
        check("rst_ack", 32'(ack), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            after_edge();
            check("rst_no_ack", 32'(ack), 0);
        end

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 16; i++) regs[i] = WIDTH'($urandom);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && ack[i]) begin
                    if ($urandom_range(0, 3) == 0) addr[4*i +: 4] = 4'($urandom);
                    else req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 4) == 0) begin
                        addr[4*i +: 4] = 4'($urandom);
                        req[i] = 1'b1;
                    end
                end else if (busy && ack == '0 && int'(gnt_id) == i) begin
                    if ($urandom_range(0, 7) == 0) addr[4*i +: 4] = 4'($urandom);
                    if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
        reset = 1'b0;
        req = '0;
        repeat (6) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/regread_arbiter.md
Name: regread_arbiter

Overview:
- Round-robin controller that shares one 16:1 one-hot register-read mux slice (WIDTH copies of the 16-input AND-OR/NAND mux) among NREQ requesters.
- Decodes the winning requester's 4-bit register address into the one-hot `sel` bus.
- Holds `sel` stable for SETTLE_CYCLES so the multi-level NAND tree can settle, then captures the mux result and acknowledges the requester.
- Sits between the register file's `regq` outputs/mux and the datapath units that read registers.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, data width (number of parallel mux slices)
- SETTLE_CYCLES, 2, clock cycles `sel` is held before capture (>=1; covers 7 NAND levels of delay)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester read request, level, held until ack
- addr  input  4*NREQ  register address, requester i at bits [4i+3:4i], held stable while req[i]=1
- sel  output  16  one-hot select to the mux slices (all zero when idle)
- mux_res  input  WIDTH  mux slice outputs, one bit per slice
- rdata  output  WIDTH  captured read data, valid while ack is nonzero
- ack  output  NREQ  one-hot, single-cycle completion to the granted requester
- gnt_id  output  3  index of the current/last granted requester
- busy  output  1  high in SETTLE and ACK

Behaviour:
- Reset (sync, reset=1 at an edge): state=IDLE, sel=0, ack=0, rdata=0, gnt_id=0, busy=0, settle counter=0, round-robin pointer=0.
- Reset mid-transaction abandons it; no ack is issued.
- States:
  - IDLE: if any req, arbitrate → SETTLE; else stay.
  - SETTLE: counter loaded with SETTLE_CYCLES-1 on entry; decrements each edge. When counter==0: rdata<=mux_res, ack[gnt_id]<=1, → ACK.
  - ACK: one cycle; ack and rdata valid, sel unchanged. At the next edge ack<=0, then arbitrate:
    - any eligible req → SETTLE with the new sel (no idle bubble);
    - otherwise → IDLE, sel<=0.
- Arbitration:
  - Round-robin, searching from pointer upward with wrap at NREQ-1 → 0.
  - On grant to k: pointer<=(k+1) mod NREQ, gnt_id<=k, sel<=1<<addr[4k+3:4k], all in the same edge.
  - In ACK, the just-acked requester is masked (its req is still high that cycle).
- Latency: req high before edge E in IDLE → sel valid after E → ack/rdata valid in the cycle after edge E+SETTLE_CYCLES.
  - Throughput: one read per SETTLE_CYCLES+1 cycles under continuous requests.
- `sel` changes only at entry to SETTLE or exit to IDLE; never during SETTLE. It is always one-hot or zero.
- `busy` = (state != IDLE).
- Boundaries:
  - Requester dropping req during SETTLE: transaction still completes and ack pulses; no abort.
  - addr changes while granted: ignored (sel latched at grant).
  - Sole requester re-requesting immediately: masked in ACK, so it is granted from IDLE one cycle later.
  - All NREQ requesting: each is served exactly once per NREQ transactions, in pointer order.
  - addr=15 and addr=0 decode to sel=16'h8000 and 16'h0001.

Test Plan:
- Reset then idle, no req → sel=0, ack=0, rdata=0, busy=0 every cycle. Assert reset during SETTLE → next cycle state IDLE, sel=0, no ack pulse.
- Single read: SETTLE_CYCLES=2, req[1]=1, addr1=4'd5, mux_res driven 16'hA5C3 once sel=16'h0020 → sel=16'h0020 after edge E; ack=4'b0010 and rdata=16'hA5C3 in the cycle after E+2; sel=0 afterward.
- Round-robin: req=4'b1111 held, addrs 0,3,7,15 → grants 0,1,2,3,0… with sel 0001,0008,0080,8000; one ack every 3 cycles; no bubble between transactions.
- Sole repeater: req[2] held high with addr 9 → ack[2] pulses every 4 cycles (one IDLE cycle between), sel=16'h0200 during each SETTLE.
- Drop during SETTLE: req[0] deasserts one cycle after grant → ack[0] still pulses, rdata captured; next grant goes to another pending requester.
- Address hold: addr3 changes from 2 to 11 mid-SETTLE → sel stays 16'h0004 until the transaction ends.
